// File: rtl/audio_pkg.sv
// Shared audio-path definitions.
//   flap_state_t : flap detector FSM states
//   SAMPLE_W     : width of one signed microphone sample
//   LEVEL_W      : width of the unsigned magnitude/level value
package audio_pkg;

  localparam int SAMPLE_W = 32;
  localparam int LEVEL_W  = 16;

  typedef enum logic [1:0] {
    QUIET   = 2'd0,
    LOUD    = 2'd1,
    HOLDOFF = 2'd2
  } flap_state_t;

endpackage

// File: rtl/sample_magnitude.sv
// Combinational magnitude of a stereo sample pair.
//   left_sample  : signed left sample
//   right_sample : signed right sample
//   mag          : max(|L|, |R|) with |x| saturated to 2^31-1, bits [30:15]
module sample_magnitude
  import audio_pkg::*;
(
  input  logic [SAMPLE_W-1:0] left_sample,
  input  logic [SAMPLE_W-1:0] right_sample,
  output logic [LEVEL_W-1:0]  mag
);

  function automatic logic [LEVEL_W-1:0] mag16(input logic [SAMPLE_W-1:0] x);
    logic [SAMPLE_W-1:0] a;
    a = x[SAMPLE_W-1] ? (~x + SAMPLE_W'(1)) : x;
    // Only -2^31 still has the sign bit after negation; clamp it to full scale.
    if (a[SAMPLE_W-1]) a = {1'b0, {(SAMPLE_W-1){1'b1}}};
    return a[30:15];
  endfunction

  logic [LEVEL_W-1:0] mag_l;
  logic [LEVEL_W-1:0] mag_r;

  always_comb begin
    mag_l = mag16(left_sample);
    mag_r = mag16(right_sample);
    mag   = (mag_l > mag_r) ? mag_l : mag_r;
  end

endmodule

// File: rtl/mic_flap_detector.sv
// Microphone flap detector: pops samples from the audio input FIFO, tracks the
// peak magnitude per 2^WINDOW_LOG2-sample window and turns loud windows into
// single-cycle flap events with hysteresis and a hold-off.
//   CLOCK_50               : clock
//   resetn                 : async active-low reset
//   audio_in_available     : input FIFO has a sample pair
//   left/right_channel_audio_in : signed samples
//   read_audio_in          : registered pop strobe (consume cycle)
//   flap_pulse             : one-cycle flap event
//   loud                   : FSM is in LOUD
//   level                  : peak magnitude of the last completed window
module mic_flap_detector
  import audio_pkg::*;
#(
  parameter int                 WINDOW_LOG2     = 9,
  parameter logic [LEVEL_W-1:0] THRESH_ON       = 16'd4000,
  parameter logic [LEVEL_W-1:0] THRESH_OFF      = 16'd2000,
  parameter int                 HOLDOFF_WINDOWS = 8
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                audio_in_available,
  input  logic [SAMPLE_W-1:0] left_channel_audio_in,
  input  logic [SAMPLE_W-1:0] right_channel_audio_in,
  output logic                read_audio_in,
  output logic                flap_pulse,
  output logic                loud,
  output logic [LEVEL_W-1:0]  level
);

  localparam int HOLD_W = 16;

  logic [WINDOW_LOG2-1:0] cnt;
  logic [LEVEL_W-1:0]     peak;
  logic [LEVEL_W-1:0]     smp_mag;
  logic [LEVEL_W-1:0]     peak_upd;
  logic                   consume;
  logic                   win_close;

  flap_state_t            state, state_nx;
  logic [HOLD_W-1:0]      hold, hold_nx;
  logic                   flap_nx;

  sample_magnitude u_mag (
    .left_sample  (left_channel_audio_in),
    .right_sample (right_channel_audio_in),
    .mag          (smp_mag)
  );

  // The pop strobe itself marks the cycle in which the pair is taken.
  assign consume   = read_audio_in;
  assign win_close = consume & (&cnt);
  assign peak_upd  = (smp_mag > peak) ? smp_mag : peak;
  assign loud      = (state == LOUD);

  // Handshake and window datapath
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      read_audio_in <= 1'b0;
      cnt           <= '0;
      peak          <= '0;
      level         <= '0;
    end else begin
      // Alternate pops so FIFO flags settle between reads.
      read_audio_in <= audio_in_available & ~read_audio_in;
      if (consume) begin
        cnt <= cnt + WINDOW_LOG2'(1);
        if (win_close) begin
          peak  <= '0;
          level <= peak_upd;
        end else begin
          peak  <= peak_upd;
        end
      end
    end
  end

  // FSM state register
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state      <= QUIET;
      hold       <= '0;
      flap_pulse <= 1'b0;
    end else begin
      state      <= state_nx;
      hold       <= hold_nx;
      flap_pulse <= flap_nx;
    end
  end

  // FSM next state; only advances when a window closes.
  always_comb begin
    state_nx = state;
    hold_nx  = hold;
    flap_nx  = 1'b0;
    if (win_close) begin
      unique case (state)
        QUIET: begin
          if (peak_upd >= THRESH_ON) begin
            flap_nx  = 1'b1;
            state_nx = LOUD;
          end
        end
        LOUD: begin
          if (peak_upd < THRESH_OFF) begin
            state_nx = HOLDOFF;
            hold_nx  = HOLD_W'(HOLDOFF_WINDOWS - 1);
          end
        end
        HOLDOFF: begin
          if (hold == '0) state_nx = QUIET;
          else            hold_nx  = hold - HOLD_W'(1);
        end
        default: state_nx = QUIET;
      endcase
    end
  end

endmodule
